// File: rtl/y86_inst_encoder_pkg.sv
// ============================================================================
// Module      : y86_inst_encoder_pkg
// Description : Y86-64 icode values, instruction lengths, encoder state type
//               and the wire-order byte packing helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package y86_inst_encoder_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] C_LEN_NONE = 4'd0;
    localparam logic [3:0] C_LEN_1    = 4'd1;
    localparam logic [3:0] C_LEN_2    = 4'd2;
    localparam logic [3:0] C_LEN_9    = 4'd9;
    localparam logic [3:0] C_LEN_10   = 4'd10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    // Byte 0 of the instruction lands in bits [7:0]; unused upper bytes are zero.
    function automatic logic [79:0] f_pack(
        input logic [3:0]  icode,
        input logic [3:0]  ifun,
        input logic [3:0]  ra,
        input logic [3:0]  rb,
        input logic [63:0] valc,
        input logic [3:0]  len
    );
        logic [7:0] w_op;
        logic [7:0] w_regs;
        w_op   = {icode, ifun};
        w_regs = {ra, rb};
        case (len)
            C_LEN_1: return {72'd0, w_op};
            C_LEN_2: return {64'd0, w_regs, w_op};
            C_LEN_9: return {8'd0, valc, w_op};
            default: return {valc, w_regs, w_op};
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/y86_inst_encoder_len.sv
// ============================================================================
// Module      : y86_inst_len
// Description : Combinational {icode,ifun} -> instruction length and validity.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module y86_inst_len
    import y86_inst_encoder_pkg::*;
(
    input  logic [3:0] i_icode,
    input  logic [3:0] i_ifun,
    output logic [3:0] o_len,
    output logic       o_valid
);

    always_comb begin
        o_len   = C_LEN_NONE;
        o_valid = 1'b0;
        case (i_icode)
            I_HALT, I_NOP, I_RET: begin
                o_valid = (i_ifun == 4'd0);
                o_len   = C_LEN_1;
            end
            I_CMOVXX: begin
                o_valid = (i_ifun < 4'd7);
                o_len   = C_LEN_2;
            end
            I_OPQ: begin
                o_valid = (i_ifun < 4'd4);
                o_len   = C_LEN_2;
            end
            I_PUSHQ, I_POPQ: begin
                o_valid = (i_ifun == 4'd0);
                o_len   = C_LEN_2;
            end
            I_JXX: begin
                o_valid = (i_ifun < 4'd7);
                o_len   = C_LEN_9;
            end
            I_CALL: begin
                o_valid = (i_ifun == 4'd0);
                o_len   = C_LEN_9;
            end
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                o_valid = (i_ifun == 4'd0);
                o_len   = C_LEN_10;
            end
            default: begin
                o_valid = 1'b0;
                o_len   = C_LEN_NONE;
            end
        endcase
        if (!o_valid) begin
            o_len = C_LEN_NONE;
        end
    end

endmodule

`default_nettype wire

// File: rtl/y86_inst_encoder.sv
// ============================================================================
// Module      : y86_inst_encoder
// Description : Serialises decoded Y86-64 fields into byte-wide instruction
//               memory, one byte per cycle, tracking the next write address.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module y86_inst_encoder
    import y86_inst_encoder_pkg::*;
#(
    parameter int MEM_DEPTH = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              base_load,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_icode,
    input  logic [3:0]        in_ifun,
    input  logic [3:0]        in_rA,
    input  logic [3:0]        in_rB,
    input  logic [63:0]       in_valC,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              done,
    output logic              i_error,
    output logic              mem_error
);

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_start;
    logic [3:0]        r_k;
    logic [3:0]        r_len;
    logic [79:0]       r_shift;
    logic              r_i_error;
    logic              r_mem_error;

    logic [3:0]        w_len;
    logic              w_valid;
    logic              w_hs;
    logic [ADDR_W:0]   w_end;
    logic              w_overrun;
    logic              w_last;

    y86_inst_len u_len (
        .i_icode (in_icode),
        .i_ifun  (in_ifun),
        .o_len   (w_len),
        .o_valid (w_valid)
    );

    assign in_ready  = (r_state == ST_IDLE) && !base_load;
    assign w_hs      = in_valid && in_ready;
    // One extra bit so an instruction ending exactly at MEM_DEPTH is not an overrun.
    assign w_end     = {1'b0, r_wr_ptr} + (ADDR_W+1)'(w_len);
    assign w_overrun = (w_end > (ADDR_W+1)'(MEM_DEPTH));
    assign w_last    = (r_k == (r_len - 4'd1));

    assign wr_ptr    = r_wr_ptr;
    assign i_error   = r_i_error;
    assign mem_error = r_mem_error;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = 8'd0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_hs && w_valid && !w_overrun) begin
                    w_state_next = ST_EMIT;
                end
            end
            ST_EMIT: begin
                mem_we    = 1'b1;
                mem_addr  = r_start + ADDR_W'(r_k);
                mem_wdata = r_shift[7:0];
                if (w_last) begin
                    done         = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_start     <= '0;
            r_k         <= 4'd0;
            r_len       <= 4'd0;
            r_shift     <= 80'd0;
            r_i_error   <= 1'b0;
            r_mem_error <= 1'b0;
        end else begin
            r_i_error   <= 1'b0;
            r_mem_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (base_load) begin
                        r_wr_ptr <= base_addr;
                    end else if (in_valid) begin
                        if (!w_valid) begin
                            r_i_error <= 1'b1;
                        end else if (w_overrun) begin
                            r_mem_error <= 1'b1;
                        end else begin
                            r_start <= r_wr_ptr;
                            r_len   <= w_len;
                            r_k     <= 4'd0;
                            r_shift <= f_pack(in_icode, in_ifun, in_rA, in_rB,
                                              in_valC, w_len);
                        end
                    end
                end
                ST_EMIT: begin
                    r_shift <= r_shift >> 8;
                    r_k     <= r_k + 4'd1;
                    if (w_last) begin
                        r_wr_ptr <= r_start + ADDR_W'(r_len);
                    end
                end
                default: begin
                    r_k <= 4'd0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_y86_inst_encoder.sv
// ============================================================================
// Module      : tb_y86_inst_encoder
// Description : Self-checking bench for y86_inst_encoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_y86_inst_encoder;

    localparam int ADDR_W    = 10;
    localparam int MEM_DEPTH = 1024;

    logic              clk;
    logic              rst_n;
    logic              base_load;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_icode;
    logic [3:0]        in_ifun;
    logic [3:0]        in_rA;
    logic [3:0]        in_rB;
    logic [63:0]       in_valC;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [ADDR_W-1:0] wr_ptr;
    logic              done;
    logic              i_error;
    logic              mem_error;

    y86_inst_encoder #(.MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .base_load (base_load),
        .base_addr (base_addr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_icode  (in_icode),
        .in_ifun   (in_ifun),
        .in_rA     (in_rA),
        .in_rB     (in_rB),
        .in_valC   (in_valC),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .wr_ptr    (wr_ptr),
        .done      (done),
        .i_error   (i_error),
        .mem_error (mem_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          ld;
        int          base;
        logic [3:0]  ic;
        logic [3:0]  ifn;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] vc;
        int          len;
        int          ierr;
        int          merr;
        logic [79:0] bytes;
        int          start;
        int          ptr;
    } vec_t;

    vec_t tbl[12];

    // Observations gathered while an instruction is being processed.
    int          n_wr;
    int          n_done;
    int          done_at;
    int          n_ierr;
    int          n_merr;
    int          ready_low;
    bit          addr_ok;
    logic [79:0] got_bytes;
    logic [ADDR_W-1:0] got_addr0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int model_len(input logic [3:0] ic, input logic [3:0] ifn);
        case (ic)
            4'h0, 4'h1, 4'h9: return (ifn == 0) ? 1 : 0;
            4'h2:             return (ifn < 7)  ? 2 : 0;
            4'h6:             return (ifn < 4)  ? 2 : 0;
            4'hA, 4'hB:       return (ifn == 0) ? 2 : 0;
            4'h7:             return (ifn < 7)  ? 9 : 0;
            4'h8:             return (ifn == 0) ? 9 : 0;
            4'h3, 4'h4, 4'h5: return (ifn == 0) ? 10 : 0;
            default:          return 0;
        endcase
    endfunction

    function automatic logic [79:0] model_bytes(input logic [3:0] ic, input logic [3:0] ifn,
                                                input logic [3:0] ra, input logic [3:0] rb,
                                                input logic [63:0] vc, input int len);
        logic [7:0]  q[$];
        logic [79:0] r;
        q.push_back({ic, ifn});
        if (len == 2 || len == 10) q.push_back({ra, rb});
        if (len >= 9) for (int i = 0; i < 8; i++) q.push_back(vc[8*i +: 8]);
        r = '0;
        foreach (q[i]) r[8*i +: 8] = q[i];
        return r;
    endfunction

    task automatic set_base(input int a);
        @(negedge clk);
        base_load = 1'b1;
        base_addr = ADDR_W'(a);
        in_valid  = 1'b1;
        in_icode  = 4'h1;
        in_ifun   = 4'h0;
        #1;
        chk("base_ready_low", in_ready, 1'b0);
        @(posedge clk);
        #1;
        base_load = 1'b0;
        in_valid  = 1'b0;
        chk("base_ptr", wr_ptr, a);
        @(negedge clk);
        chk("base_no_write", mem_we, 1'b0);
    endtask

    task automatic send(input logic [3:0] ic, input logic [3:0] ifn, input logic [3:0] ra,
                        input logic [3:0] rb, input logic [63:0] vc);
        bit fin;
        @(negedge clk);
        chk("ready_before", in_ready, 1'b1);
        in_icode = ic; in_ifun = ifn; in_rA = ra; in_rB = rb; in_valC = vc;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        n_wr = 0; n_done = 0; done_at = 0; n_ierr = 0; n_merr = 0; ready_low = 0;
        addr_ok = 1'b1; got_bytes = '0; got_addr0 = '0; fin = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (mem_we) begin
                if (n_wr == 0) got_addr0 = mem_addr;
                else if (mem_addr !== got_addr0 + ADDR_W'(n_wr)) addr_ok = 1'b0;
                if (n_wr < 10) got_bytes[8*n_wr +: 8] = mem_wdata;
                n_wr++;
                if (done) done_at = n_wr;
            end
            if (done)      n_done++;
            if (i_error)   n_ierr++;
            if (mem_error) n_merr++;
            if (in_ready) begin
                fin = 1'b1;
                break;
            end
            ready_low++;
        end
        if (!fin) chk("timeout_ready", 1'b0, 1'b1);
    endtask

    task automatic verify(input string tag, input int exp_len, input int exp_ierr,
                          input int exp_merr, input logic [79:0] exp_bytes,
                          input int exp_start, input int exp_ptr);
        chk($sformatf("%s/writes", tag), n_wr, exp_len);
        chk($sformatf("%s/i_error", tag), n_ierr, exp_ierr);
        chk($sformatf("%s/mem_error", tag), n_merr, exp_merr);
        chk($sformatf("%s/done_cnt", tag), n_done, (exp_len > 0) ? 1 : 0);
        chk($sformatf("%s/ready_low", tag), ready_low, exp_len);
        if (exp_len > 0) begin
            chk($sformatf("%s/bytes", tag), got_bytes, exp_bytes);
            chk($sformatf("%s/start", tag), got_addr0, exp_start);
            chk($sformatf("%s/addr_seq", tag), addr_ok, 1'b1);
            chk($sformatf("%s/done_pos", tag), done_at, exp_len);
        end
        chk($sformatf("%s/wr_ptr", tag), wr_ptr, exp_ptr);
    endtask

    initial begin
        int model_ptr;
        int cnt;
        int b;
        int len;
        logic [3:0]  ic, ifn, ra, rb;
        logic [63:0] vc;

        tbl[0]  = '{1, 0,    4'h3, 4'h0, 4'hF, 4'h1, 64'd18, 10, 0, 0, {64'd18, 8'hF1, 8'h30}, 0, 10};
        tbl[1]  = '{1, 66,   4'h7, 4'h4, 4'hF, 4'hF, 64'h1E, 9, 0, 0, {8'h00, 64'h1E, 8'h74}, 66, 75};
        tbl[2]  = '{1, 0,    4'h6, 4'h0, 4'h2, 4'h0, 64'hDEAD, 2, 0, 0, {64'h0, 8'h20, 8'h60}, 0, 2};
        tbl[3]  = '{0, 0,    4'h9, 4'h0, 4'hF, 4'hF, 64'hBEEF, 1, 0, 0, {72'h0, 8'h90}, 2, 3};
        tbl[4]  = '{0, 0,    4'h6, 4'h4, 4'h1, 4'h2, 64'h0, 0, 1, 0, 80'h0, 0, 3};
        tbl[5]  = '{0, 0,    4'hC, 4'h0, 4'h1, 4'h2, 64'h0, 0, 1, 0, 80'h0, 0, 3};
        tbl[6]  = '{1, 1015, 4'h4, 4'h0, 4'h1, 4'h2, 64'h11, 0, 0, 1, 80'h0, 0, 1015};
        tbl[7]  = '{1, 1014, 4'h4, 4'h0, 4'h1, 4'h2, 64'h0102030405060708, 10, 0, 0,
                    {64'h0102030405060708, 8'h12, 8'h40}, 1014, 0};
        tbl[8]  = '{1, 1020, 4'h3, 4'h1, 4'hF, 4'h1, 64'h0, 0, 1, 0, 80'h0, 0, 1020};
        tbl[9]  = '{1, 1023, 4'h0, 4'h0, 4'hF, 4'hF, 64'h55, 1, 0, 0, {72'h0, 8'h00}, 1023, 0};
        tbl[10] = '{1, 1016, 4'h8, 4'h0, 4'hF, 4'hF, 64'h0123456789ABCDEF, 0, 0, 1, 80'h0, 0, 1016};
        tbl[11] = '{1, 1015, 4'h8, 4'h0, 4'hF, 4'hF, 64'h0123456789ABCDEF, 9, 0, 0,
                    {8'h00, 64'h0123456789ABCDEF, 8'h80}, 1015, 0};

        rst_n = 1'b0; base_load = 1'b0; base_addr = '0; in_valid = 1'b0;
        in_icode = '0; in_ifun = '0; in_rA = '0; in_rB = '0; in_valC = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst/mem_we", mem_we, 1'b0);
        chk("rst/mem_addr", mem_addr, 0);
        chk("rst/mem_wdata", mem_wdata, 0);
        chk("rst/wr_ptr", wr_ptr, 0);
        chk("rst/done", done, 1'b0);
        chk("rst/errors", {i_error, mem_error}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst/in_ready", in_ready, 1'b1);

        for (int i = 0; i < 12; i++) begin
            if (tbl[i].ld) set_base(tbl[i].base);
            send(tbl[i].ic, tbl[i].ifn, tbl[i].ra, tbl[i].rb, tbl[i].vc);
            verify($sformatf("tbl%0d", i), tbl[i].len, tbl[i].ierr, tbl[i].merr,
                   tbl[i].bytes, tbl[i].start, tbl[i].ptr);
        end

        // base_load during EMIT must not disturb the pointer update.
        set_base(100);
        @(negedge clk);
        in_icode = 4'h3; in_ifun = 4'h0; in_rA = 4'hF; in_rB = 4'h2; in_valC = 64'h7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        base_load = 1'b1;
        base_addr = ADDR_W'(500);
        @(posedge clk);
        #1;
        base_load = 1'b0;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!in_ready && cnt < 20);
        chk("emit_base_ignored", wr_ptr, 110);

        // Reset asserted while the 5th byte is on the bus.
        set_base(0);
        @(negedge clk);
        in_icode = 4'h3; in_ifun = 4'h0; in_rA = 4'hF; in_rB = 4'h1; in_valC = 64'd18;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mem_we) cnt++;
            if (cnt == 5) break;
        end
        chk("midrst/reached5", cnt, 5);
        rst_n = 1'b0;
        #1;
        chk("midrst/mem_we", mem_we, 1'b0);
        chk("midrst/done", done, 1'b0);
        chk("midrst/addr_data", {mem_addr, mem_wdata}, 0);
        chk("midrst/wr_ptr", wr_ptr, 0);
        chk("midrst/errors", {i_error, mem_error}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst/in_ready", in_ready, 1'b1);
        chk("midrst/idle", mem_we, 1'b0);

        model_ptr = 0;
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                b = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1005, 1023))
                                                : int'($urandom_range(0, 1023));
                set_base(b);
                model_ptr = b;
            end
            ic  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) ifn = 4'($urandom_range(0, 15));
            else ifn = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(0, 6));
            ra  = 4'($urandom_range(0, 15));
            rb  = 4'($urandom_range(0, 15));
            vc  = {$urandom, $urandom};
            len = model_len(ic, ifn);
            send(ic, ifn, ra, rb, vc);
            if (len == 0) begin
                verify($sformatf("rnd%0d", n), 0, 1, 0, 80'h0, 0, model_ptr);
            end else if (model_ptr + len > MEM_DEPTH) begin
                verify($sformatf("rnd%0d", n), 0, 0, 1, 80'h0, 0, model_ptr);
            end else begin
                verify($sformatf("rnd%0d", n), len, 0, 0, model_bytes(ic, ifn, ra, rb, vc, len),
                       model_ptr, (model_ptr + len) % MEM_DEPTH);
                model_ptr = (model_ptr + len) % MEM_DEPTH;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
